// File: rtl/local_mem_arbiter.sv
// Two-requester arbiter for a single-port, 1-cycle-latency local memory.
// Round-robin between A and B, with a bounded lock so a read-modify-write pair issues back to back.
module local_mem_arbiter #(
  parameter int LOCK_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        a_lock,
  input  logic [29:0] a_addr,
  input  logic [3:0]  a_be,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_lock,
  input  logic [29:0] b_addr,
  input  logic [3:0]  b_be,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic        mem_en,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);
  localparam logic [3:0] LIMIT = 4'(LOCK_LIMIT);

  logic       last_gnt;     // 0 = A, 1 = B
  logic       lock_active;
  logic       lock_owner;
  logic [3:0] lock_cnt;
  logic       rsp_a, rsp_b;
  logic       gnt_lock;

  // Under a lock the non-owner is refused even when the memory would be idle.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst) begin
      if (lock_active) begin
        a_gnt = !lock_owner && a_req;
        b_gnt =  lock_owner && b_req;
      end else if (a_req && b_req) begin
        a_gnt =  last_gnt;
        b_gnt = !last_gnt;
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  always_comb begin
    mem_en      = a_gnt || b_gnt;
    mem_addr    = b_gnt ? b_addr  : a_addr;
    mem_data_in = b_gnt ? b_wdata : a_wdata;
    mem_be      = a_gnt ? a_be : (b_gnt ? b_be : 4'h0);
    gnt_lock    = (a_gnt && a_lock) || (b_gnt && b_lock);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt    <= 1'b1;
      lock_active <= 1'b0;
      lock_owner  <= 1'b0;
      lock_cnt    <= 4'h0;
      rsp_a       <= 1'b0;
      rsp_b       <= 1'b0;
    end else begin
      rsp_a <= a_gnt && (a_be == 4'h0);
      rsp_b <= b_gnt && (b_be == 4'h0);
      if (mem_en) last_gnt <= b_gnt;
      // Once the owner has used LIMIT locked grants its next lock request is ignored.
      if (gnt_lock && (lock_cnt < LIMIT)) begin
        lock_active <= 1'b1;
        lock_owner  <= b_gnt;
        lock_cnt    <= lock_cnt + 4'h1;
      end else begin
        lock_active <= 1'b0;
        lock_cnt    <= 4'h0;
      end
    end
  end

  assign a_rvalid = rsp_a;
  assign b_rvalid = rsp_b;
  assign a_rdata  = mem_data_out;
  assign b_rdata  = mem_data_out;
endmodule

// File: tb/tb_local_mem_arbiter.sv
// Bench for local_mem_arbiter: directed scenarios with literal expectations plus
// a per-cycle reference model of who owns the memory each cycle.
module tb_local_mem_arbiter;
  localparam int LOCK_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_lock, b_req, b_lock;
  logic [29:0] a_addr, b_addr;
  logic [3:0]  a_be, b_be;
  logic [31:0] a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_en;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out = 32'h0;

  int total = 0;
  int bad   = 0;

  local_mem_arbiter #(.LOCK_LIMIT(LOCK_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_lock(a_lock), .a_addr(a_addr), .a_be(a_be), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_lock(b_lock), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [29:0] a);
    return (a == 30'h10) ? 32'hDEADBEEF : ({a, 2'b00} ^ 32'h5A5A_0000);
  endfunction

  // Memory stand-in: read data appears the cycle after a read enable.
  always @(posedge clk)
    if (mem_en && mem_be == 4'h0) mem_data_out <= memfn(mem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who is preferred on a tie, who the next cycle is reserved for,
  // how many locked grants in a row, and which reads are owed data next cycle.
  int          m_pref = 0;
  int          m_resv = -1;
  int          m_streak = 0;
  logic        m_pend_a = 1'b0, m_pend_b = 1'b0;
  logic [29:0] m_paddr = '0;
  int          win;
  logic [1:0]  rq, lk;
  logic [29:0] w_addr;
  logic [3:0]  w_be;
  logic [31:0] w_data;

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_reset_outs", {a_gnt, b_gnt, mem_en, a_rvalid, b_rvalid}, 32'h0);
      m_pref = 0; m_resv = -1; m_streak = 0; m_pend_a = 1'b0; m_pend_b = 1'b0;
    end else begin
      chk("m_a_rvalid", a_rvalid, m_pend_a);
      chk("m_b_rvalid", b_rvalid, m_pend_b);
      if (m_pend_a) chk("m_a_rdata", a_rdata, memfn(m_paddr));
      if (m_pend_b) chk("m_b_rdata", b_rdata, memfn(m_paddr));
      rq = {b_req, a_req};
      lk = {b_lock, a_lock};
      if (m_resv >= 0)        win = rq[m_resv] ? m_resv : -1;
      else if (rq == 2'b11)   win = m_pref;
      else if (rq[0])         win = 0;
      else if (rq[1])         win = 1;
      else                    win = -1;
      chk("m_a_gnt", a_gnt, win == 0);
      chk("m_b_gnt", b_gnt, win == 1);
      chk("m_mem_en", mem_en, win >= 0);
      w_addr = (win == 1) ? b_addr  : a_addr;
      w_be   = (win == 1) ? b_be    : a_be;
      w_data = (win == 1) ? b_wdata : a_wdata;
      if (win >= 0) begin
        chk("m_mem_addr", mem_addr, w_addr);
        chk("m_mem_be", mem_be, w_be);
        if (w_be != 4'h0) chk("m_mem_data", mem_data_in, w_data);
      end else chk("m_mem_be_idle", mem_be, 4'h0);
      m_pend_a = (win == 0) && (w_be == 4'h0);
      m_pend_b = (win == 1) && (w_be == 4'h0);
      m_paddr  = w_addr;
      if (win >= 0) m_pref = 1 - win;
      if (win >= 0 && lk[win] && m_streak < LOCK_LIMIT) begin
        m_resv = win; m_streak++;
      end else begin
        m_resv = -1; m_streak = 0;
      end
    end
  end

  task automatic drv(input logic ar, input logic al, input logic [29:0] aa, input logic [3:0] abe,
                     input logic br, input logic bl, input logic [29:0] ba, input logic [3:0] bbe);
    @(posedge clk); #1;
    a_req = ar; a_lock = al; a_addr = aa; a_be = abe; a_wdata = 32'hA000_0000 | 32'(aa);
    b_req = br; b_lock = bl; b_addr = ba; b_be = bbe; b_wdata = 32'hB000_0000 | 32'(ba);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    a_req = 1'b1; a_lock = 1'b0; a_addr = 30'h1; a_be = 4'h0; a_wdata = '0;
    b_req = 1'b1; b_lock = 1'b0; b_addr = 30'h2; b_be = 4'h0; b_wdata = '0;
    // Reset held with both requesting
    repeat (2) @(negedge clk);
    chk("rst_gnts", {a_gnt, b_gnt, mem_en}, 3'b000);
    chk("rst_rvalid", {a_rvalid, b_rvalid}, 2'b00);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("first_tie_a", {a_gnt, b_gnt}, 2'b10);

    // Single B read
    drv(0, 0, 30'h0, 4'h0, 1, 0, 30'h10, 4'h0);
    @(negedge clk);
    chk("sr_b_gnt", b_gnt, 1'b1);
    chk("sr_mem_addr", mem_addr, 30'h10);
    chk("sr_mem_be", {mem_en, mem_be}, 5'b1_0000);
    drv(0, 0, 30'h0, 4'h0, 0, 0, 30'h0, 4'h0);
    @(negedge clk);
    chk("sr_b_rvalid", {b_rvalid, a_rvalid}, 2'b10);
    chk("sr_b_rdata", b_rdata, 32'hDEADBEEF);

    // Contention: both read continuously; last grant was B so A first
    for (int i = 0; i < 4; i++) begin
      drv(1, 0, 30'h21, 4'h0, 1, 0, 30'h22, 4'h0);
      @(negedge clk);
      chk("cont_gnts", {a_gnt, b_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    drv(0, 0, 30'h0, 4'h0, 0, 0, 30'h0, 4'h0);

    // AMO: locked read then write, B waits
    drv(1, 1, 30'h5, 4'h0, 1, 0, 30'h6, 4'h0);
    @(negedge clk);
    chk("amo_c0_a_gnt", a_gnt, 1'b1);
    drv(1, 0, 30'h5, 4'hF, 1, 0, 30'h6, 4'h0);
    @(negedge clk);
    chk("amo_c1_gnts", {a_gnt, b_gnt, a_rvalid}, 3'b101);
    chk("amo_c1_wdata", mem_data_in, 32'hA000_0005);
    drv(0, 0, 30'h0, 4'h0, 1, 0, 30'h6, 4'h0);
    @(negedge clk);
    chk("amo_c2_b_gnt", b_gnt, 1'b1);
    drv(0, 0, 30'h0, 4'h0, 0, 0, 30'h0, 4'h0);

    // Lock limit: A holds a_lock for 6 cycles against a waiting B
    for (int i = 0; i < 6; i++) begin
      drv(1, 1, 30'h30, 4'h0, 1, 0, 30'h31, 4'h0);
      @(negedge clk);
      chk("ll_gnts", {a_gnt, b_gnt}, (i < 5) ? 2'b10 : 2'b01);
    end
    // Counter restarted: a fresh lock reserves the next cycle again
    drv(1, 1, 30'h32, 4'h0, 0, 0, 30'h0, 4'h0);
    @(negedge clk);
    chk("ll_relock", a_gnt, 1'b1);
    drv(0, 0, 30'h0, 4'h0, 1, 0, 30'h33, 4'h0);
    @(negedge clk);
    chk("ll_relock_block", {b_gnt, mem_en}, 2'b00);
    drv(0, 0, 30'h0, 4'h0, 1, 0, 30'h33, 4'h0);
    @(negedge clk);
    chk("ll_b_after", b_gnt, 1'b1);

    // Idle reserved cycle
    drv(1, 1, 30'h40, 4'h0, 1, 0, 30'h41, 4'h0);
    @(negedge clk);
    chk("idle_c0", {a_gnt, b_gnt}, 2'b10);
    drv(0, 0, 30'h0, 4'h0, 1, 0, 30'h41, 4'h0);
    @(negedge clk);
    chk("idle_c1", {mem_en, b_gnt}, 2'b00);
    drv(0, 0, 30'h0, 4'h0, 1, 0, 30'h41, 4'h0);
    @(negedge clk);
    chk("idle_c2", b_gnt, 1'b1);

    // Reset mid-operation: pending read and lock are both discarded
    drv(1, 1, 30'h50, 4'h0, 0, 0, 30'h0, 4'h0);
    @(negedge clk);
    chk("rmid_a_gnt", a_gnt, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0; a_req = 1'b0; a_lock = 1'b0; b_req = 1'b1; b_addr = 30'h51; b_be = 4'h0;
    @(negedge clk);
    chk("rmid_rvalid", {a_rvalid, b_gnt}, 2'b00);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rmid_no_rvalid", a_rvalid, 1'b0);
    chk("rmid_b_gnt", b_gnt, 1'b1);

    // Mixed traffic against the model
    for (int i = 0; i < 80; i++)
      drv(1'($urandom), 1'($urandom), 30'($urandom_range(0, 31)), ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
          1'($urandom), 1'($urandom), 30'($urandom_range(0, 31)), ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom));
    drv(0, 0, 30'h0, 4'h0, 0, 0, 30'h0, 4'h0);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
